// File: rtl/dma2d_pkg.sv
// dma2d_pkg: shared state encoding, chunk command type and size constants for the 2D DMA row sequencer.
package dma2d_pkg;
  localparam int DMA2D_4K_BYTES = 4096;
  localparam int DMA2D_LEN_W = 13;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CALC = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  typedef enum logic [2:0] {
    ST_IDLE = S_IDLE,
    ST_CALC = S_CALC,
    ST_ISSUE = S_ISSUE,
    ST_DRAIN = S_DRAIN,
    ST_DONE = S_DONE
  } state_e;
  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [DMA2D_LEN_W-1:0] len;
    logic last;
  } cmd_t;
endpackage

// File: rtl/dma2d_chunk_calc.sv
// dma2d_chunk_calc: combinational chunk length = min of remaining row bytes and max chunk size.
// With DMA2D_4K_SPLIT_EN defined, the length is also clipped so neither src nor dst crosses a 4 KB boundary.
module dma2d_chunk_calc
  import dma2d_pkg::*;
#(
  parameter int C_MAX_CHUNK_BYTES = 256
) (
  input  logic [31:0]            i_row_rem,
  input  logic [31:0]            i_src,
  input  logic [31:0]            i_dst,
  output logic [DMA2D_LEN_W-1:0] o_len
);
  localparam logic [DMA2D_LEN_W-1:0] MAX_LEN = DMA2D_LEN_W'(C_MAX_CHUNK_BYTES);
  logic [DMA2D_LEN_W-1:0] row_lim;
  assign row_lim = (i_row_rem < 32'(C_MAX_CHUNK_BYTES)) ? i_row_rem[DMA2D_LEN_W-1:0] : MAX_LEN;
`ifdef DMA2D_4K_SPLIT_EN
  logic [DMA2D_LEN_W-1:0] src_lim, dst_lim, bnd_lim;
  logic unused_hi;
  assign src_lim = DMA2D_LEN_W'(DMA2D_4K_BYTES) - {1'b0, i_src[11:0]};
  assign dst_lim = DMA2D_LEN_W'(DMA2D_4K_BYTES) - {1'b0, i_dst[11:0]};
  assign bnd_lim = (src_lim < dst_lim) ? src_lim : dst_lim;
  assign o_len = (bnd_lim < row_lim) ? bnd_lim : row_lim;
  assign unused_hi = ^{i_src[31:12], i_dst[31:12]};
`else
  logic unused_addr;
  assign o_len = row_lim;
  assign unused_addr = ^{i_src, i_dst};
`endif
endmodule

// File: rtl/dma_2d_row_sequencer.sv
// dma_2d_row_sequencer: walks a 2D transfer row by row, issuing bounded chunk commands and pulsing done
// after all chunks complete. Optional DMA2D_4K_SPLIT_EN keeps chunks inside 4 KB pages.
module dma_2d_row_sequencer
  import dma2d_pkg::*;
#(
  parameter int C_MAX_CHUNK_BYTES = 256,
  parameter int C_MAX_OUTSTANDING = 8
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESETN,
  input  logic                   i_dma_start,
  input  logic [31:0]            i_src_addr,
  input  logic [31:0]            i_dst_addr,
  input  logic [31:0]            i_img_width,
  input  logic [31:0]            i_img_height,
  input  logic [31:0]            i_img_stride,
  output logic                   o_cmd_valid,
  input  logic                   i_cmd_ready,
  output logic [31:0]            o_cmd_src,
  output logic [31:0]            o_cmd_dst,
  output logic [DMA2D_LEN_W-1:0] o_cmd_len,
  output logic                   o_cmd_last,
  input  logic                   i_chunk_done,
  output logic                   o_busy,
  output logic                   o_dma_done
);
  state_e state_q, state_d;
  cmd_t cmd_q, cmd_d;
  logic [31:0] base_src_q, base_src_d, base_dst_q, base_dst_d;
  logic [31:0] cur_src_q, cur_src_d, cur_dst_q, cur_dst_d;
  logic [31:0] width_q, width_d, stride_q, stride_d;
  logic [31:0] row_rem_q, row_rem_d, rows_left_q, rows_left_d;
  logic [7:0] outst_q, outst_d;
  logic [DMA2D_LEN_W-1:0] calc_len;
  logic hs, dec;

  dma2d_chunk_calc #(.C_MAX_CHUNK_BYTES(C_MAX_CHUNK_BYTES)) u_calc (
    .i_row_rem(row_rem_q),
    .i_src    (cur_src_q),
    .i_dst    (cur_dst_q),
    .o_len    (calc_len)
  );

  assign hs = (state_q == ST_ISSUE) && i_cmd_ready;
  assign dec = i_chunk_done && (outst_q != 8'd0);

  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    base_src_d = base_src_q;
    base_dst_d = base_dst_q;
    cur_src_d = cur_src_q;
    cur_dst_d = cur_dst_q;
    width_d = width_q;
    stride_d = stride_q;
    row_rem_d = row_rem_q;
    rows_left_d = rows_left_q;
    outst_d = outst_q + 8'(hs) - 8'(dec);
    unique case (state_q)
      ST_IDLE: if (i_dma_start) begin
        base_src_d = i_src_addr;
        base_dst_d = i_dst_addr;
        cur_src_d = i_src_addr;
        cur_dst_d = i_dst_addr;
        width_d = i_img_width;
        stride_d = i_img_stride;
        row_rem_d = i_img_width;
        rows_left_d = i_img_height;
        state_d = (i_img_width == 32'd0 || i_img_height == 32'd0) ? ST_DONE : ST_CALC;
      end
      ST_CALC: if (outst_q != 8'(C_MAX_OUTSTANDING)) begin
        cmd_d = '{src: cur_src_q, dst: cur_dst_q, len: calc_len,
                  last: (rows_left_q == 32'd1) && (32'(calc_len) == row_rem_q)};
        state_d = ST_ISSUE;
      end
      ST_ISSUE: if (i_cmd_ready) begin
        cur_src_d = cur_src_q + 32'(cmd_q.len);
        cur_dst_d = cur_dst_q + 32'(cmd_q.len);
        row_rem_d = row_rem_q - 32'(cmd_q.len);
        // Next row restarts from the strided base, not from where this row ended.
        if (row_rem_q == 32'(cmd_q.len)) begin
          base_src_d = base_src_q + stride_q;
          base_dst_d = base_dst_q + stride_q;
          cur_src_d = base_src_q + stride_q;
          cur_dst_d = base_dst_q + stride_q;
          row_rem_d = width_q;
          rows_left_d = rows_left_q - 32'd1;
        end
        state_d = cmd_q.last ? ST_DRAIN : ST_CALC;
      end
      ST_DRAIN: state_d = (outst_d == 8'd0) ? ST_DONE : ST_DRAIN;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state_q <= ST_IDLE;
      cmd_q <= '0;
      base_src_q <= '0;
      base_dst_q <= '0;
      cur_src_q <= '0;
      cur_dst_q <= '0;
      width_q <= '0;
      stride_q <= '0;
      row_rem_q <= '0;
      rows_left_q <= '0;
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      base_src_q <= base_src_d;
      base_dst_q <= base_dst_d;
      cur_src_q <= cur_src_d;
      cur_dst_q <= cur_dst_d;
      width_q <= width_d;
      stride_q <= stride_d;
      row_rem_q <= row_rem_d;
      rows_left_q <= rows_left_d;
      outst_q <= outst_d;
    end
  end

  assign o_cmd_valid = (state_q == ST_ISSUE);
  assign o_cmd_src = cmd_q.src;
  assign o_cmd_dst = cmd_q.dst;
  assign o_cmd_len = cmd_q.len;
  assign o_cmd_last = cmd_q.last;
  assign o_busy = (state_q == ST_CALC) || (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign o_dma_done = (state_q == ST_DONE);
endmodule

// File: tb/tb_dma_2d_row_sequencer.sv
// tb_dma_2d_row_sequencer: directed scoreboard bench for dma_2d_row_sequencer (max chunk 256, max outstanding 2).
module tb_dma_2d_row_sequencer;
  logic S_AXI_ACLK = 1'b0;
  logic S_AXI_ARESETN, i_dma_start, i_cmd_ready, i_chunk_done;
  logic [31:0] i_src_addr, i_dst_addr, i_img_width, i_img_height, i_img_stride;
  logic o_cmd_valid, o_cmd_last, o_busy, o_dma_done;
  logic [31:0] o_cmd_src, o_cmd_dst;
  logic [12:0] o_cmd_len;
  logic [77:0] dut_pl, hold_pl;
  logic [77:0] exp_q[$];
  int n_cmp = 0, n_err = 0, done_cnt = 0, hs_cnt = 0, pend = 0;
  logic prev_dn = 1'b0, hold = 1'b0;

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  dma_2d_row_sequencer #(.C_MAX_CHUNK_BYTES(256), .C_MAX_OUTSTANDING(2)) dut (
    .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESETN(S_AXI_ARESETN), .i_dma_start(i_dma_start),
    .i_src_addr(i_src_addr), .i_dst_addr(i_dst_addr), .i_img_width(i_img_width),
    .i_img_height(i_img_height), .i_img_stride(i_img_stride), .o_cmd_valid(o_cmd_valid),
    .i_cmd_ready(i_cmd_ready), .o_cmd_src(o_cmd_src), .o_cmd_dst(o_cmd_dst), .o_cmd_len(o_cmd_len),
    .o_cmd_last(o_cmd_last), .i_chunk_done(i_chunk_done), .o_busy(o_busy), .o_dma_done(o_dma_done)
  );

  assign dut_pl = {o_cmd_src, o_cmd_dst, o_cmd_len, o_cmd_last};

  function automatic logic [77:0] pl(input logic [31:0] s, input logic [31:0] d, input int l, input logic last);
    return {s, d, 13'(l), last};
  endfunction

  task automatic chk(input string tag, input logic [77:0] obs, input logic [77:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string t);
    chk({t, "_valid"}, 78'(o_cmd_valid), 78'(0));
    chk({t, "_src"}, 78'(o_cmd_src), 78'(0));
    chk({t, "_dst"}, 78'(o_cmd_dst), 78'(0));
    chk({t, "_len"}, 78'(o_cmd_len), 78'(0));
    chk({t, "_last"}, 78'(o_cmd_last), 78'(0));
    chk({t, "_busy"}, 78'(o_busy), 78'(0));
    chk({t, "_done"}, 78'(o_dma_done), 78'(0));
  endtask

  // One cycle: drive inputs at the negedge, score what the next posedge will sample, advance.
  task automatic cyc(input logic rdy, input logic echo, input logic man_dn);
    logic dn;
    dn = man_dn || (echo && pend > 0);
    if (echo && pend > 0) pend--;
    i_cmd_ready = rdy;
    i_chunk_done = dn;
    if (o_cmd_valid && hold) chk("payload_hold", dut_pl, hold_pl);
    if (o_cmd_valid && rdy) begin
      hs_cnt++;
      pend++;
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_err++;
        $error("FAIL cmd_extra: observed %0h expected none", dut_pl);
      end
      if (exp_q.size() > 0) chk("cmd", dut_pl, exp_q.pop_front());
    end
    hold = o_cmd_valid && !rdy;
    hold_pl = dut_pl;
    if (o_dma_done) begin
      done_cnt++;
      chk("busy_at_done", 78'(o_busy), 78'(0));
      chk("done_lag", 78'(prev_dn), 78'(1));
    end
    prev_dn = dn;
    @(negedge S_AXI_ACLK);
  endtask

  task automatic start(input logic [31:0] s, input logic [31:0] d, input logic [31:0] w,
                       input logic [31:0] h, input logic [31:0] st);
    i_src_addr = s; i_dst_addr = d; i_img_width = w; i_img_height = h; i_img_stride = st;
    i_dma_start = 1'b1;
    i_chunk_done = 1'b0;
    @(negedge S_AXI_ACLK);
    i_dma_start = 1'b0;
    done_cnt = 0; hs_cnt = 0; pend = 0; hold = 1'b0; prev_dn = 1'b0;
  endtask

  task automatic run(input int budget, input logic rnd);
    for (int i = 0; i < budget && done_cnt == 0; i++) cyc(rnd ? 1'($urandom) : 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("done_count", 78'(done_cnt), 78'(1));
    chk("queue_left", 78'(exp_q.size()), 78'(0));
  endtask

  task automatic push_row600();
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(pl(32'h2000 + r * 1024, 32'h3000 + r * 1024, 256, 1'b0));
      exp_q.push_back(pl(32'h2100 + r * 1024, 32'h3100 + r * 1024, 256, 1'b0));
      exp_q.push_back(pl(32'h2200 + r * 1024, 32'h3200 + r * 1024, 88, r == 1));
    end
  endtask

  task automatic push_4k();
`ifdef DMA2D_4K_SPLIT_EN
    exp_q.push_back(pl(32'h0F80, 32'h20000, 128, 1'b0));
    exp_q.push_back(pl(32'h1000, 32'h20080, 128, 1'b1));
`else
    exp_q.push_back(pl(32'h0F80, 32'h20000, 256, 1'b1));
`endif
  endtask

  initial begin
    S_AXI_ARESETN = 1'b0; i_dma_start = 1'b0; i_cmd_ready = 1'b0; i_chunk_done = 1'b0;
    i_src_addr = '0; i_dst_addr = '0; i_img_width = '0; i_img_height = '0; i_img_stride = '0;
    repeat (3) @(negedge S_AXI_ACLK);
    chk_idle("reset");
    S_AXI_ARESETN = 1'b1;
    @(negedge S_AXI_ACLK);
    // 4 full rows of 256 bytes, stride 1024
    for (int k = 0; k < 4; k++) exp_q.push_back(pl(32'h1000 + k * 1024, 32'h8000 + k * 1024, 256, k == 3));
    start(32'h1000, 32'h8000, 256, 4, 1024);
    chk("busy_after_start", 78'(o_busy), 78'(1));
    chk("no_valid_in_calc", 78'(o_cmd_valid), 78'(0));
    run(200, 1'b0);
    // rows split into 256/256/88
    push_row600();
    start(32'h2000, 32'h3000, 600, 2, 1024);
    run(200, 1'b0);
    // 4 KB boundary straddle
    push_4k();
    start(32'h0F80, 32'h20000, 256, 1, 0);
    run(100, 1'b0);
    // zero-size transfers
    start(32'h100, 32'h200, 0, 3, 64);
    chk("zw_done", 78'(o_dma_done), 78'(1));
    chk("zw_valid", 78'(o_cmd_valid), 78'(0));
    chk("zw_busy", 78'(o_busy), 78'(0));
    @(negedge S_AXI_ACLK);
    chk("zw_done_gone", 78'(o_dma_done), 78'(0));
    chk("zw_valid_late", 78'(o_cmd_valid), 78'(0));
    start(32'h100, 32'h200, 16, 0, 64);
    chk("zh_done", 78'(o_dma_done), 78'(1));
    chk("zh_valid", 78'(o_cmd_valid), 78'(0));
    @(negedge S_AXI_ACLK);
    // outstanding limit of 2 with completions withheld
    for (int k = 0; k < 5; k++) exp_q.push_back(pl(32'h4000 + k * 256, 32'h5000 + k * 256, 256, k == 4));
    start(32'h4000, 32'h5000, 1280, 1, 2048);
    repeat (10) cyc(1'b1, 1'b0, 1'b0);
    chk("stall_at_2", 78'(hs_cnt), 78'(2));
    cyc(1'b1, 1'b0, 1'b1);
    repeat (9) cyc(1'b1, 1'b0, 1'b0);
    chk("one_release", 78'(hs_cnt), 78'(3));
    cyc(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10 && !o_cmd_valid; i++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, o_cmd_valid);
    repeat (8) cyc(1'b1, 1'b0, 1'b0);
    chk("same_cycle_done", 78'(hs_cnt), 78'(5));
    cyc(1'b1, 1'b0, 1'b1);
    repeat (4) cyc(1'b1, 1'b0, 1'b0);
    chk("drain_wait", 78'(done_cnt), 78'(0));
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("drain_done", 78'(done_cnt), 78'(1));
    chk("drain_queue", 78'(exp_q.size()), 78'(0));
    // random backpressure, plus a start pulse while busy that must be ignored
    push_row600();
    start(32'h2000, 32'h3000, 600, 2, 1024);
    repeat (5) cyc(1'($urandom), 1'b1, 1'b0);
    i_src_addr = 32'hDEAD0000; i_img_width = 16; i_img_height = 1; i_dma_start = 1'b1;
    cyc(1'($urandom), 1'b1, 1'b0);
    i_dma_start = 1'b0;
    run(400, 1'b1);
    // reset while a command is being offered
    start(32'h1000, 32'h8000, 256, 4, 1024);
    for (int i = 0; i < 10 && !o_cmd_valid; i++) cyc(1'b0, 1'b0, 1'b0);
    chk("in_issue", 78'(o_cmd_valid), 78'(1));
    S_AXI_ARESETN = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    chk_idle("mid_reset");
    S_AXI_ARESETN = 1'b1;
    done_cnt = 0; hs_cnt = 0;
    cyc(1'b1, 1'b0, 1'b1);
    repeat (5) cyc(1'b1, 1'b0, 1'b0);
    chk("no_done_after_reset", 78'(done_cnt), 78'(0));
    chk("no_cmd_after_reset", 78'(hs_cnt), 78'(0));
    chk("idle_after_reset", 78'(o_busy), 78'(0));
    push_4k();
    start(32'h0F80, 32'h20000, 256, 1, 0);
    run(100, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
